fetch_ctrl: RTL

Instruction-fetch sequencer that drives the PC register's next-PC mux select and load enable, and runs the request/response handshake to instruction memory. It keeps at most one fetch outstanding and holds each returned instruction, with its PC, in a one-entry output register until decode accepts it. On a taken branch or JALR redirect from execute, it discards any wrong-path fetch. It sits between the PC register, instruction memory and the IF/ID boundary.

---
 rtl/fetch_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC mux select/enable, single-outstanding imem
// handshake, wrong-path squash on redirect, and a one-entry IF/ID holding register.
module fetch_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  br_taken_i,
  input  logic                  jalr_i,
  output logic                  pc_en_o,
  output logic [1:0]            pc_src_o,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  if_valid_o,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic [DATA_WIDTH-1:0] if_pc_o,
  input  logic                  id_ready_i
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    redir;
  logic                    fill;
  logic                    pop;
  logic                    grant;
  logic [DATA_WIDTH-1:0]   req_pc;

  assign imem_addr_o = pc_i;

  always_comb begin
    redir      = br_taken_i | jalr_i;
    pc_src_o   = 2'b00;
    if (jalr_i)          pc_src_o = 2'b10;
    else if (br_taken_i) pc_src_o = 2'b01;

    // Only request when the holding register will have room at the next edge.
    imem_req_o = (state == REQ) & ~rst & ~redir & (~if_valid_o | id_ready_i);
    grant      = imem_req_o & imem_gnt_i;
    pc_en_o    = redir | grant;
    pop        = if_valid_o & id_ready_i;
    fill       = (state == WAIT) & imem_rvalid_i & ~redir;

    state_nxt  = state;
    unique case (state)
      REQ: begin
        if (grant) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) state_nxt = REQ;
        else if (redir)    state_nxt = KILL;
      end
      KILL: begin
        if (imem_rvalid_i) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      req_pc     <= '0;
      if_valid_o <= 1'b0;
      if_instr_o <= '0;
      if_pc_o    <= '0;
    end else begin
      state <= state_nxt;
      if (grant) req_pc <= pc_i;
      if (redir) begin
        if_valid_o <= 1'b0;
      end else if (fill) begin
        if_valid_o <= 1'b1;
        if_instr_o <= imem_rdata_i;
        if_pc_o    <= req_pc;
      end else if (pop) begin
        if_valid_o <= 1'b0;
      end
    end
  end

endmodule
